// File: rtl/sprite_framebuffer_renderer_pkg.sv
// Shared types and constants for the sprite renderer: FSM states, glyph layout, letter codes.
// Pure declarations; no timing or backpressure of its own.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    SWAP  = 2'd3
  } render_state_t;

  localparam int GLYPH_BITS    = 30;
  localparam int GLYPH_ROWS    = 5;
  localparam int TRIP_W        = 3;
  localparam int LEFT_MSB      = 29;
  localparam int RIGHT_MSB     = 14;
  localparam int RIGHT_COL_OFS = 5;

  localparam logic [7:0] CODE_A     = 8'h41;
  localparam logic [7:0] CODE_B     = 8'h42;
  localparam logic [7:0] CODE_C     = 8'h43;
  localparam logic [7:0] CODE_BLOCK = 8'h7F;

  // {left rows 0..4, right rows 0..4}, each row a 3-bit triplet, MSB = rightmost pixel
  localparam logic [GLYPH_BITS-1:0] GLYPH_A     = 30'b010_101_111_101_101_111_100_110_100_111;
  localparam logic [GLYPH_BITS-1:0] GLYPH_B     = 30'b110_101_110_101_110_011_100_100_100_011;
  localparam logic [GLYPH_BITS-1:0] GLYPH_C     = 30'b011_100_100_100_011_101_101_010_101_101;
  localparam logic [GLYPH_BITS-1:0] GLYPH_BLOCK = 30'h3FFF_FFFF;

endpackage

// File: rtl/sprite_framebuffer_renderer_glyph_rom.sv
// Letter-code to 30-bit glyph lookup; combinational, zero latency, no backpressure.
// Unknown codes render as an empty glyph.
module glyph_rom
  import sprite_pkg::*;
(
  input  logic [7:0]            code,
  output logic [GLYPH_BITS-1:0] glyph
);

  always_comb begin
    case (code)
      CODE_A:     glyph = GLYPH_A;
      CODE_B:     glyph = GLYPH_B;
      CODE_C:     glyph = GLYPH_C;
      CODE_BLOCK: glyph = GLYPH_BLOCK;
      default:    glyph = '0;
    endcase
  end

endmodule

// File: rtl/sprite_framebuffer_renderer.sv
// Double-buffered sprite renderer: clear + draw back buffer, then swap; FB_H+NUM_SPRITES*GLYPH_H+1 edges per frame.
// Never stalls: a start while busy is held as one pending request and served at the swap.
module sprite_framebuffer_renderer
  import sprite_pkg::*;
#(
  parameter int FB_W        = 40,
  parameter int FB_H        = 30,
  parameter int NUM_SPRITES = 3,
  parameter int YW          = 5,
  parameter int Y_LIMIT     = 22,
  parameter int ROW_BASE    = 2,
  parameter int COL_BASE    = 6,
  parameter int COL_PITCH   = 10,
  parameter int GLYPH_H     = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NUM_SPRITES*8-1:0]  letters,
  input  logic [NUM_SPRITES*YW-1:0] ypos,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  output logic [FB_W*FB_H-1:0]      framebuffer,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = $clog2(FB_W*FB_H) + 1;
  localparam int RW = (FB_H > 1) ? $clog2(FB_H) : 1;
  localparam int SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int GW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  render_state_t             state;
  logic [RW-1:0]             row_cnt;
  logic [SW-1:0]             spr_cnt;
  logic [GW-1:0]             grow_cnt;
  logic                      pending;
  logic [NUM_SPRITES*8-1:0]  snap_letters;
  logic [NUM_SPRITES*YW-1:0] snap_ypos;
  logic [NUM_SPRITES-1:0]    snap_en;

  logic [FB_W-1:0]           back [FB_H];

  logic [7:0]                cur_code;
  logic [YW-1:0]             cur_y;
  logic                      cur_en;
  logic [GLYPH_BITS-1:0]     cur_glyph;
  logic [TRIP_W-1:0]         left_trip;
  logic [TRIP_W-1:0]         right_trip;
  logic [AW-1:0]             trow;
  logic [AW-1:0]             col_x;
  logic                      draw_we;
  logic [FB_W-1:0]           row_mask;

  always_comb begin
    cur_code = '0;
    cur_y    = '0;
    cur_en   = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (spr_cnt == SW'(i)) begin
        cur_code = snap_letters[i*8 +: 8];
        cur_y    = snap_ypos[i*YW +: YW];
        cur_en   = snap_en[i];
      end
    end
  end

  glyph_rom u_glyph_rom (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  always_comb begin
    left_trip  = '0;
    right_trip = '0;
    for (int r = 0; r < GLYPH_ROWS; r++) begin
      if (grow_cnt == GW'(r)) begin
        left_trip  = cur_glyph[LEFT_MSB  - TRIP_W*r -: TRIP_W];
        right_trip = cur_glyph[RIGHT_MSB - TRIP_W*r -: TRIP_W];
      end
    end
  end

  assign trow    = AW'(ROW_BASE) + AW'(cur_y) + AW'(grow_cnt);
  assign col_x   = AW'(COL_BASE) + AW'(spr_cnt) * AW'(COL_PITCH);
  assign draw_we = (state == DRAW) && cur_en && (AW'(cur_y) < AW'(Y_LIMIT)) && (trow < AW'(FB_H));

  // Triplet LSB lands on the lower column; columns past FB_W simply match no mask bit.
  always_comb begin
    row_mask = '0;
    for (int k = 0; k < TRIP_W; k++) begin
      for (int c = 0; c < FB_W; c++) begin
        if (AW'(c) == col_x + AW'(k))
          row_mask[c] = left_trip[k];
        if (AW'(c) == col_x + AW'(RIGHT_COL_OFS + k))
          row_mask[c] = right_trip[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      row_cnt      <= '0;
      spr_cnt      <= '0;
      grow_cnt     <= '0;
      pending      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      snap_letters <= '0;
      snap_ypos    <= '0;
      snap_en      <= '0;
    end else begin
      done <= 1'b0;
      if (start && state != IDLE)
        pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            snap_letters <= letters;
            snap_ypos    <= ypos;
            snap_en      <= sprite_en;
            busy         <= 1'b1;
            row_cnt      <= '0;
            state        <= CLEAR;
          end
        end
        CLEAR: begin
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == RW'(FB_H-1)) begin
            spr_cnt  <= '0;
            grow_cnt <= '0;
            state    <= DRAW;
          end
        end
        DRAW: begin
          if (grow_cnt == GW'(GLYPH_H-1)) begin
            grow_cnt <= '0;
            if (spr_cnt == SW'(NUM_SPRITES-1))
              state <= SWAP;
            else
              spr_cnt <= spr_cnt + 1'b1;
          end else begin
            grow_cnt <= grow_cnt + 1'b1;
          end
        end
        SWAP: begin
          done <= 1'b1;
          // A request seen during this frame (or right now) restarts from live inputs.
          if (pending || start) begin
            snap_letters <= letters;
            snap_ypos    <= ypos;
            snap_en      <= sprite_en;
            pending      <= 1'b0;
            row_cnt      <= '0;
            state        <= CLEAR;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      framebuffer <= '0;
      for (int r = 0; r < FB_H; r++)
        back[r] <= '0;
    end else begin
      case (state)
        CLEAR: begin
          for (int r = 0; r < FB_H; r++)
            if (row_cnt == RW'(r))
              back[r] <= '0;
        end
        DRAW: begin
          for (int r = 0; r < FB_H; r++)
            if (draw_we && trow == AW'(r))
              back[r] <= back[r] | row_mask;
        end
        SWAP: begin
          for (int r = 0; r < FB_H; r++)
            framebuffer[r*FB_W +: FB_W] <= back[r];
        end
        default: ;
      endcase
    end
  end

endmodule
